// File: rtl/muldiv_sequencer_if.sv
// Handshake and control bundle between the main control unit and the
// multiply/divide sequencer.
interface muldiv_sequencer_if;
    logic       start;
    logic [1:0] op;
    logic       divisor_zero;
    logic       busy;
    logic       init;
    logic       mult_on;
    logic       div_on;
    logic       div_srcA;
    logic       div_srcB;
    logic       hi_write;
    logic       lo_write;
    logic       hi_src;
    logic       lo_src;
    logic       dzero;
    logic       done;

    // Control unit side: issues requests, observes sequencing outputs.
    modport master (
        output start, op, divisor_zero,
        input  busy, init, mult_on, div_on, div_srcA, div_srcB,
               hi_write, lo_write, hi_src, lo_src, dzero, done
    );

    // Sequencer side.
    modport slave (
        input  start, op, divisor_zero,
        output busy, init, mult_on, div_on, div_srcA, div_srcB,
               hi_write, lo_write, hi_src, lo_src, dzero, done
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Moore sequencer for the shared iterative multiply/divide unit: load,
// ITER step cycles, Hi/Lo commit (or divide-by-zero), one-cycle done.
module muldiv_sequencer #(
    parameter int ITER  = 32,
    parameter int CNT_W = 6
) (
    input logic               clk,
    input logic               reset,
    muldiv_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4,
        S_DZ    = 3'd5
    } state_t;

    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_DIVM = 2'b10;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic start_is_div;
    logic op_is_div;
    logic op_is_divm;

    assign start_is_div = (bus.op == OP_DIV) || (bus.op == OP_DIVM);
    // Reserved op 11 falls out as MULT because only 01/10 count as divides.
    assign op_is_div    = (op_q == OP_DIV) || (op_q == OP_DIVM);
    assign op_is_divm   = (op_q == OP_DIVM);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= 2'b00;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        cnt_d        = cnt_q;
        bus.busy     = 1'b1;
        bus.init     = 1'b0;
        bus.mult_on  = 1'b0;
        bus.div_on   = 1'b0;
        bus.div_srcA = 1'b0;
        bus.div_srcB = 1'b0;
        bus.hi_write = 1'b0;
        bus.lo_write = 1'b0;
        bus.hi_src   = 1'b0;
        bus.lo_src   = 1'b0;
        bus.dzero    = 1'b0;
        bus.done     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                bus.busy = 1'b0;
                if (bus.start) begin
                    op_d    = bus.op;
                    state_d = (start_is_div && bus.divisor_zero) ? S_DZ : S_LOAD;
                end
            end
            S_LOAD: begin
                bus.init     = 1'b1;
                bus.div_srcA = op_is_divm;
                bus.div_srcB = op_is_divm;
                cnt_d        = '0;
                state_d      = S_RUN;
            end
            S_RUN: begin
                bus.mult_on  = ~op_is_div;
                bus.div_on   = op_is_div;
                bus.div_srcA = op_is_divm;
                bus.div_srcB = op_is_divm;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_WRITE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WRITE: begin
                bus.hi_write = 1'b1;
                bus.lo_write = 1'b1;
                bus.hi_src   = op_is_div;
                bus.lo_src   = op_is_div;
                bus.div_srcA = op_is_divm;
                bus.div_srcB = op_is_divm;
                state_d      = S_DONE;
            end
            S_DONE: begin
                bus.done = 1'b1;
                state_d  = S_IDLE;
            end
            S_DZ: begin
                bus.dzero = 1'b1;
                bus.done  = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                bus.busy = 1'b0;
                state_d  = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: checks every output, cycle by cycle,
// against the documented timing for each operation.
module tb_muldiv_sequencer;
    logic clk;
    logic reset;
    int   passed;
    int   total;
    int   fails;

    muldiv_sequencer_if bus ();

    muldiv_sequencer #(.ITER(32), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {busy,init,mult_on,div_on,srcA,srcB,hi_w,lo_w,hi_src,lo_src,dzero,done}
    function automatic logic [11:0] outs();
        return {bus.busy, bus.init, bus.mult_on, bus.div_on, bus.div_srcA, bus.div_srcB,
                bus.hi_write, bus.lo_write, bus.hi_src, bus.lo_src, bus.dzero, bus.done};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected output vector in cycle c after the start edge (c=1 is LOAD).
    function automatic logic [11:0] expect_vec(input int c, input logic [1:0] op_v, input logic dz_v);
        logic is_div, is_divm, run, wr;
        is_div  = (op_v == 2'b01) || (op_v == 2'b10);
        is_divm = (op_v == 2'b10);
        if (is_div && dz_v)
            return (c == 1) ? 12'b1000_0000_0011 : 12'b0;
        run = (c >= 2) && (c <= 33);
        wr  = (c == 34);
        return {(c >= 1 && c <= 35), (c == 1), run && !is_div, run && is_div,
                is_divm && c >= 1 && c <= 34, is_divm && c >= 1 && c <= 34,
                wr, wr, wr && is_div, wr && is_div, 1'b0, (c == 35)};
    endfunction

    task automatic run_op(input string name, input logic [1:0] op_v, input logic dz_v, input bit poke);
        int inits, dones, mults, divs;
        logic is_div;
        inits = 0; dones = 0; mults = 0; divs = 0;
        is_div = (op_v == 2'b01) || (op_v == 2'b10);
        bus.start = 1'b1;
        bus.op = op_v;
        bus.divisor_zero = dz_v;
        step();
        bus.start = 1'b0;
        bus.divisor_zero = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            chk($sformatf("%s_c%0d", name, c), 32'(outs()), 32'(expect_vec(c, op_v, dz_v)));
            inits += int'(bus.init);
            dones += int'(bus.done);
            mults += int'(bus.mult_on);
            divs  += int'(bus.div_on);
            // Ignored requests: mid-run and in the DONE cycle, with a tempting DZ op.
            if (poke && (c == 10 || c == 35)) begin
                bus.start = 1'b1;
                bus.op = 2'b01;
                bus.divisor_zero = 1'b1;
            end else begin
                bus.start = 1'b0;
                bus.op = op_v;
                bus.divisor_zero = 1'b0;
            end
            if (c < 40) step();
        end
        chk({name, "_inits"}, 32'(inits), (is_div && dz_v) ? 32'd0 : 32'd1);
        chk({name, "_dones"}, 32'(dones), 32'd1);
        chk({name, "_mult_cnt"}, 32'(mults), (is_div || (is_div && dz_v)) ? 32'd0 : 32'd32);
        chk({name, "_div_cnt"}, 32'(divs), (is_div && !dz_v) ? 32'd32 : 32'd0);
        $display("txn %s op=%b dz=%b inits=%0d dones=%0d mult=%0d div=%0d",
                 name, op_v, dz_v, inits, dones, mults, divs);
    endtask

    initial begin
        int hits;
        passed = 0; total = 0; fails = 0;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.op = 2'b00;
        bus.divisor_zero = 1'b0;
        step();
        step();
        reset = 1'b0;
        chk("reset_outs", 32'(outs()), 32'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("idle_%0d", i), 32'(outs()), 32'd0);
        end
        $display("txn reset_idle outs=%h", outs());

        run_op("mult",      2'b00, 1'b0, 1'b0);
        run_op("divm",      2'b10, 1'b0, 1'b0);
        run_op("div",       2'b01, 1'b0, 1'b0);
        run_op("div_zero",  2'b01, 1'b1, 1'b0);
        run_op("divm_zero", 2'b10, 1'b1, 1'b0);
        run_op("mult_dzig", 2'b00, 1'b1, 1'b0);
        run_op("op11",      2'b11, 1'b0, 1'b0);
        run_op("busy_poke", 2'b00, 1'b0, 1'b1);

        // Reset asserted during RUN aborts with no commit.
        bus.start = 1'b1;
        bus.op = 2'b00;
        step();
        bus.start = 1'b0;
        for (int c = 1; c < 15; c++) step();
        chk("mid_run_mult_on", 32'(bus.mult_on), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("reset_abort_outs", 32'(outs()), 32'd0);
        hits = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            hits += int'(bus.done | bus.hi_write | bus.lo_write | bus.busy);
        end
        chk("post_abort_quiet", 32'(hits), 32'd0);
        $display("txn reset_abort activity=%0d", hits);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Sequencer for the shared iterative multiply/divide resource in the multicycle MIPS datapath. The main control unit issues a one-cycle start pulse for MULT, DIV or DIVM. This block then:
- loads the operand registers;
- steps the iterative datapath for a fixed number of cycles;
- commits the result to Hi/Lo, or raises a divide-by-zero exception;
- returns a one-cycle done pulse so the control unit can leave its wait state.

## Interface
Parameters:
- ITER, 32, number of step cycles per operation (≥2).
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > ITER.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request pulse from control unit; honoured only in IDLE.
- op  in  2  operation: 00 MULT, 01 DIV, 10 DIVM, 11 reserved (treated as MULT).
- divisor_zero  in  1  datapath flag: selected divisor equals 0; sampled only with an accepted DIV/DIVM start.
- busy  out  1  high in every state except IDLE.
- init  out  1  load operand/accumulator registers of the selected unit.
- mult_on  out  1  multiplier step enable.
- div_on  out  1  divider step enable.
- div_srcA  out  1  dividend source: 0 = register A, 1 = MDR (DIVM).
- div_srcB  out  1  divisor source: 0 = register B, 1 = MDR (DIVM).
- hi_write  out  1  Hi register write enable.
- lo_write  out  1  Lo register write enable.
- hi_src  out  1  Hi input mux: 0 multiplier, 1 divider.
- lo_src  out  1  Lo input mux: 0 multiplier, 1 divider.
- dzero  out  1  divide-by-zero exception pulse to the control unit (EPC/exception path).
- done  out  1  completion pulse, one cycle.

## Operation
- All outputs are decoded from the registered state and the latched op (Moore); no combinational path from inputs to outputs.
- The op is latched into op_q on an accepted start.
- States:
  - IDLE: all outputs 0.
    - start=1 with op in {DIV, DIVM} and divisor_zero=1 → DZ.
    - Any other start=1 → LOAD.
  - LOAD, 1 cycle:
    - init=1.
    - div_srcA = div_srcB = (op_q==DIVM).
    - Counter cleared to 0.
    - → RUN.
  - RUN: mult_on=1 for MULT, or div_on=1 for DIV/DIVM. Counter increments each cycle. When counter == ITER-1 → WRITE (exactly ITER step cycles).
  - WRITE, 1 cycle:
    - hi_write = lo_write = 1.
    - hi_src = lo_src = (op_q != MULT).
    - → DONE.
  - DONE, 1 cycle: done=1 → IDLE.
  - DZ, 1 cycle: dzero=1 and done=1; Hi/Lo not written → IDLE.
- div_srcA/div_srcB stay at the latched value from LOAD through WRITE so the divider sees stable operands.
- A start pulse arriving while busy=1 is ignored and not queued.
- op=11 is sequenced as MULT.
- Counter is CNT_W bits wide, never wraps in normal use, and is don't-care outside RUN.

## Timing
- Reset (synchronous): state=IDLE, op_q=00, counter=0. Every output is 0 in the cycle after the reset edge.
- Reset asserted mid-operation aborts immediately: no hi_write, lo_write, done or dzero is produced.
- Latency: start sampled at edge E0.
  - LOAD occupies the cycle after E0.
  - RUN occupies the next ITER cycles.
  - WRITE follows, then DONE.
  - done is high in cycle E0+ITER+3; with ITER=32 that is cycle 35.
- Divide-by-zero latency: dzero and done are high in cycle E0+1.
- Back-to-back operation: a start in the DONE cycle is ignored because busy=1. The earliest accepted next start is in the first IDLE cycle, i.e. two cycles after WRITE.
- busy rises the cycle after an accepted start and falls in the cycle after DONE/DZ.

## Test plan
- Reset then idle: reset=1 for 2 cycles, then 0 → every output is 0; busy stays 0 with start=0 for 10 cycles.
- MULT, ITER=32, start at cycle 0:
  - init=1 at cycle 1.
  - mult_on=1 for cycles 2–33, div_on=0 throughout.
  - hi_write = lo_write = 1 with hi_src = lo_src = 0 at cycle 34.
  - done=1 at cycle 35; busy=0 at cycle 36.
- DIVM with divisor_zero=0:
  - div_srcA = div_srcB = 1 from cycle 1 through 34.
  - div_on=1 for exactly 32 cycles.
  - hi_src = lo_src = 1 on the write cycle.
  - done at cycle 35.
- DIV with divisor_zero=1 at start: dzero=1 and done=1 at cycle 1 only; no init, div_on, hi_write or lo_write ever asserted; busy=0 at cycle 2.
- Start while busy: a second start at cycle 10 and again in the DONE cycle → exactly one init and one done observed; mult_on count still 32.
- Reset mid-RUN: reset=1 at cycle 15 → IDLE at cycle 16 with all outputs 0; no done, hi_write or lo_write in the following 40 cycles.
